// File: rtl/hex_display_driver.sv
// Six-digit active-low seven-segment driver: accepts a packed hex value over a valid/ready
// port and re-encodes it one digit per cycle (MSD first), with leading-zero blanking and blink.
module hex_display_driver #(
  parameter int unsigned DIGITS        = 6,
  parameter int unsigned BLINK_DIV     = 25_000_000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [4*DIGITS-1:0]    load_value,
  input  logic [DIGITS-1:0]      load_blink_mask,
  output logic                   busy,
  output logic [DIGITS-1:0][6:0] hex_out
);

  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W    = $clog2(BLINK_DIV);
  localparam int unsigned LAST_IDX = DIGITS - 1;
  localparam int unsigned CNT_LAST = BLINK_DIV - 1;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [DIGITS-1:0][3:0]   value_q, value_d;
  logic [DIGITS-1:0]        mask_pend_q, mask_pend_d;
  logic [DIGITS-1:0]        mask_q, mask_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     seen_nz_q, seen_nz_d;
  logic [DIGITS-1:0][6:0]   code_q, code_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     phase_q, phase_d;

  logic                     accept_c;
  logic                     step_c;
  logic                     last_c;
  logic [3:0]               nibble_c;
  logic                     blank_c;
  logic                     wrap_c;

  // Active-low a..g patterns for 0-F.
  function automatic logic [6:0] seg_encode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (load_valid) state_d = S_UPDATE;
      S_UPDATE: if (idx_q == '0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    accept_c   = 1'b0;
    step_c     = 1'b0;
    last_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_ready = 1'b1;
        accept_c   = load_valid;
      end
      S_UPDATE: begin
        busy   = 1'b1;
        step_c = 1'b1;
        last_c = (idx_q == '0);
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  // Digit currently being re-encoded; digit 0 is always shown even when zero.
  assign nibble_c = value_q[idx_q];
  assign blank_c  = BLANK_LEADING && !seen_nz_q && (nibble_c == 4'h0) && (idx_q != '0);

  always_comb begin
    value_d     = value_q;
    mask_pend_d = mask_pend_q;
    mask_d      = mask_q;
    idx_d       = idx_q;
    seen_nz_d   = seen_nz_q;
    code_d      = code_q;
    if (accept_c) begin
      value_d     = load_value;
      mask_pend_d = load_blink_mask;
      idx_d       = IDX_W'(LAST_IDX);
      seen_nz_d   = 1'b0;
    end else if (step_c) begin
      code_d[idx_q] = blank_c ? SEG_BLANK : seg_encode(nibble_c);
      seen_nz_d     = seen_nz_q | (nibble_c != 4'h0);
      idx_d         = idx_q - IDX_W'(1);
      if (last_c) begin
        mask_d = mask_pend_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q     <= '0;
      mask_pend_q <= '0;
      mask_q      <= '0;
      idx_q       <= '0;
      seen_nz_q   <= 1'b0;
      code_q      <= {DIGITS{SEG_BLANK}};
    end else begin
      value_q     <= value_d;
      mask_pend_q <= mask_pend_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      seen_nz_q   <= seen_nz_d;
      code_q      <= code_d;
    end
  end

  // Free-running blink timebase, independent of loads.
  assign wrap_c  = (cnt_q == CNT_W'(CNT_LAST));
  assign cnt_d   = wrap_c ? '0 : cnt_q + CNT_W'(1);
  assign phase_d = wrap_c ? ~phase_q : phase_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DIGITS); i++) begin
      hex_out[i] = (phase_q && mask_q[i]) ? SEG_BLANK : code_q[i];
    end
  end

endmodule
